// File: rtl/ls_mem_unit.sv
// Load/store responder for the LS pipeline stage: performs one data-memory access per
// EX_LS instruction and reports completion to the hazard monitor with a one-cycle pulse.
module ls_mem_unit #(
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_LS_reg_execute_valid,
  input  logic        EX_LS_reg_load_sign_flag,
  input  logic        EX_LS_reg_store_sign_flag,
  input  logic [31:0] EX_LS_reg_addr,
  input  logic [31:0] EX_LS_reg_store_data,
  input  logic [1:0]  EX_LS_reg_size,
  input  logic        EX_LS_reg_unsigned,
  output logic        LS_MON_ls_valid,
  output logic [31:0] LS_WB_load_data,
  output logic        ls_misalign,
  output logic        ls_fault,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wstrb,
  input  logic        dmem_resp_valid,
  output logic        dmem_resp_ready,
  input  logic [31:0] dmem_resp_rdata,
  input  logic        dmem_resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(REQ_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  timeoutCnt_q, timeoutCnt_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [3:0]  reqWstrb_q, reqWstrb_d;
  logic        reqWe_q, reqWe_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        zeroExt_q, zeroExt_d;
  logic [31:0] loadData_q, loadData_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;

  logic        startAccess;
  logic        illegalSize;
  logic        misaligned;
  logic [3:0]  strbNew;
  logic [31:0] wdataNew;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;

  always_comb begin
    startAccess = EX_LS_reg_execute_valid &
                  (EX_LS_reg_load_sign_flag | EX_LS_reg_store_sign_flag);
    illegalSize = (EX_LS_reg_size == 2'b11);
    misaligned  = ((EX_LS_reg_size == 2'b01) & EX_LS_reg_addr[0]) |
                  ((EX_LS_reg_size == 2'b10) & (EX_LS_reg_addr[1:0] != 2'b00));
    strbNew  = 4'b1111;
    wdataNew = EX_LS_reg_store_data;
    case (EX_LS_reg_size)
      2'b00: begin
        strbNew  = 4'b0001 << EX_LS_reg_addr[1:0];
        wdataNew = {4{EX_LS_reg_store_data[7:0]}};
      end
      2'b01: begin
        strbNew  = 4'b0011 << EX_LS_reg_addr[1:0];
        wdataNew = {2{EX_LS_reg_store_data[15:0]}};
      end
      default: begin
        strbNew  = 4'b1111;
        wdataNew = EX_LS_reg_store_data;
      end
    endcase
  end

  // Lane extraction and extension of the returned read word.
  always_comb begin
    byteSel = dmem_resp_rdata[{lane_q, 3'b000} +: 8];
    halfSel = lane_q[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    case (size_q)
      2'b00:   loadExt = {{24{~zeroExt_q & byteSel[7]}}, byteSel};
      2'b01:   loadExt = {{16{~zeroExt_q & halfSel[15]}}, halfSel};
      default: loadExt = dmem_resp_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    reqAddr_d    = reqAddr_q;
    reqWdata_d   = reqWdata_q;
    reqWstrb_d   = reqWstrb_q;
    reqWe_d      = reqWe_q;
    lane_d       = lane_q;
    size_d       = size_q;
    zeroExt_d    = zeroExt_q;
    loadData_d   = loadData_q;
    misalign_d   = misalign_q;
    fault_d      = fault_q;

    case (state_q)
      S_IDLE: begin
        if (startAccess) begin
          timeoutCnt_d = 8'd0;
          loadData_d   = 32'd0;
          if (illegalSize) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            reqAddr_d  = {EX_LS_reg_addr[31:2], 2'b00};
            reqWe_d    = ~EX_LS_reg_load_sign_flag;
            reqWstrb_d = EX_LS_reg_load_sign_flag ? 4'b0000 : strbNew;
            reqWdata_d = wdataNew;
            lane_d     = EX_LS_reg_addr[1:0];
            size_d     = EX_LS_reg_size;
            zeroExt_d  = EX_LS_reg_unsigned;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        timeoutCnt_d = timeoutCnt_q + 8'd1;
        if (dmem_req_ready) begin
          state_d = S_RESP;
        end else if (timeoutCnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RESP: begin
        if (dmem_resp_valid) begin
          fault_d    = dmem_resp_err;
          loadData_d = (!reqWe_q && !dmem_resp_err) ? loadExt : 32'd0;
          state_d    = S_DONE;
        end
      end
      default: begin
        // Result flags are cleared as the pulse ends so they only ever qualify it.
        loadData_d   = 32'd0;
        misalign_d   = 1'b0;
        fault_d      = 1'b0;
        timeoutCnt_d = 8'd0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timeoutCnt_q <= 8'd0;
      reqAddr_q    <= 32'd0;
      reqWdata_q   <= 32'd0;
      reqWstrb_q   <= 4'd0;
      reqWe_q      <= 1'b0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      zeroExt_q    <= 1'b0;
      loadData_q   <= 32'd0;
      misalign_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      reqAddr_q    <= reqAddr_d;
      reqWdata_q   <= reqWdata_d;
      reqWstrb_q   <= reqWstrb_d;
      reqWe_q      <= reqWe_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      zeroExt_q    <= zeroExt_d;
      loadData_q   <= loadData_d;
      misalign_q   <= misalign_d;
      fault_q      <= fault_d;
    end
  end

  assign LS_MON_ls_valid = (state_q == S_DONE);
  assign dmem_req_valid  = (state_q == S_REQ);
  assign dmem_resp_ready = (state_q == S_RESP);
  assign LS_WB_load_data = loadData_q;
  assign ls_misalign     = misalign_q;
  assign ls_fault        = fault_q;
  assign dmem_req_we     = reqWe_q;
  assign dmem_req_addr   = reqAddr_q;
  assign dmem_req_wdata  = reqWdata_q;
  assign dmem_req_wstrb  = reqWstrb_q;

endmodule

// File: tb/tb_ls_mem_unit.sv
// Randomized scoreboard bench for ls_mem_unit: a memory responder, a stimulus driver
// with a behavioural model, and an independent monitor comparing against queued results.
module tb_ls_mem_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid, ldFlag, stFlag, unsFlag;
  logic [31:0] exAddr, exData;
  logic [1:0]  exSize;
  logic        LS_MON_ls_valid, ls_misalign, ls_fault;
  logic [31:0] LS_WB_load_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid, dmem_resp_ready, dmem_resp_err;
  logic [31:0] dmem_resp_rdata;

  typedef struct {
    logic [31:0] data;
    logic        misalign;
    logic        fault;
    int          lat;
    int          issue;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          cycles;
  } req_t;

  resp_t expRespQ[$];
  req_t  expReqQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checkerOff = 1'b1;

  int          curStall = 0;
  int          curRespDelay = 0;
  logic [31:0] curRdata = 32'd0;
  logic        curErr = 1'b0;

  ls_mem_unit #(.REQ_TIMEOUT(TIMEOUT)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .EX_LS_reg_execute_valid   (exValid),
    .EX_LS_reg_load_sign_flag  (ldFlag),
    .EX_LS_reg_store_sign_flag (stFlag),
    .EX_LS_reg_addr            (exAddr),
    .EX_LS_reg_store_data      (exData),
    .EX_LS_reg_size            (exSize),
    .EX_LS_reg_unsigned        (unsFlag),
    .LS_MON_ls_valid           (LS_MON_ls_valid),
    .LS_WB_load_data           (LS_WB_load_data),
    .ls_misalign               (ls_misalign),
    .ls_fault                  (ls_fault),
    .dmem_req_valid            (dmem_req_valid),
    .dmem_req_ready            (dmem_req_ready),
    .dmem_req_we               (dmem_req_we),
    .dmem_req_addr             (dmem_req_addr),
    .dmem_req_wdata            (dmem_req_wdata),
    .dmem_req_wstrb            (dmem_req_wstrb),
    .dmem_resp_valid           (dmem_resp_valid),
    .dmem_resp_ready           (dmem_resp_ready),
    .dmem_resp_rdata           (dmem_resp_rdata),
    .dmem_resp_err             (dmem_resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side: stalls req_ready per transaction, answers after a chosen delay and
  // drives noise on the response channel whenever the unit is not listening.
  initial begin
    int waitCnt = 0;
    int respCnt = 0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'd0;
    dmem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem_req_valid) begin
        dmem_req_ready = (waitCnt == curStall);
        waitCnt++;
      end else begin
        waitCnt = 0;
        dmem_req_ready = 1'($urandom_range(0, 1));
      end
      if (dmem_resp_ready) begin
        if (respCnt == curRespDelay) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_rdata = curRdata;
          dmem_resp_err   = curErr;
        end else begin
          dmem_resp_valid = 1'b0;
          dmem_resp_rdata = $urandom;
          dmem_resp_err   = 1'($urandom_range(0, 1));
        end
        respCnt++;
      end else begin
        respCnt = 0;
        dmem_resp_valid = 1'($urandom_range(0, 1));
        dmem_resp_rdata = $urandom;
        dmem_resp_err   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: checks request fields while a request is open and results on each pulse.
  initial begin
    int    reqCyclesSeen = 0;
    bit    prevReqValid = 1'b0;
    req_t  rq;
    resp_t er;
    forever begin
      @(negedge clk);
      cyc++;
      if (checkerOff || rst) begin
        reqCyclesSeen = 0;
        prevReqValid  = 1'b0;
        continue;
      end
      if (dmem_req_valid) begin
        if (expReqQ.size() == 0) begin
          checkOutput("unexpectedRequest", 32'(dmem_req_valid), 32'd0);
        end else begin
          rq = expReqQ[0];
          checkOutput("reqAddr", dmem_req_addr, rq.addr);
          checkOutput("reqWe", 32'(dmem_req_we), 32'(rq.we));
          checkOutput("reqWstrb", 32'(dmem_req_wstrb), 32'(rq.wstrb));
          if (rq.we) checkOutput("reqWdata", dmem_req_wdata, rq.wdata);
        end
        reqCyclesSeen++;
      end else if (prevReqValid) begin
        if (expReqQ.size() > 0) begin
          rq = expReqQ.pop_front();
          checkOutput("reqValidCycles", 32'(reqCyclesSeen), 32'(rq.cycles));
        end
        reqCyclesSeen = 0;
      end
      prevReqValid = dmem_req_valid;
      if (LS_MON_ls_valid) begin
        if (expRespQ.size() == 0) begin
          checkOutput("unexpectedPulse", 32'(LS_MON_ls_valid), 32'd0);
        end else begin
          er = expRespQ.pop_front();
          checkOutput("loadData", LS_WB_load_data, er.data);
          checkOutput("misalign", 32'(ls_misalign), 32'(er.misalign));
          checkOutput("fault", 32'(ls_fault), 32'(er.fault));
          checkOutput("latency", 32'(cyc - er.issue + 1), 32'(er.lat));
        end
      end
    end
  end

  // Issues one instruction, queues what the access should look like, waits for the pulse.
  task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz, input logic uns,
                               input int stall, input int rdelay, input logic [31:0] rdata,
                               input logic err);
    resp_t       er;
    req_t        rq;
    int          off;
    bit          isWrite;
    bit          seen;
    logic [31:0] ext;
    @(posedge clk);
    #1;
    off         = int'(a[1:0]);
    isWrite     = !ld && st;
    er.data     = 32'd0;
    er.misalign = 1'b0;
    er.fault    = 1'b0;
    er.lat      = 2;
    if (sz == 2'd3) begin
      er.fault = 1'b1;
    end else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0)) begin
      er.misalign = 1'b1;
    end else begin
      rq.addr  = a & 32'hFFFF_FFFC;
      rq.we    = isWrite;
      if (!isWrite)        rq.wstrb = 4'h0;
      else if (sz == 2'd0) rq.wstrb = 4'(1 << off);
      else if (sz == 2'd1) rq.wstrb = 4'(3 << off);
      else                 rq.wstrb = 4'hF;
      if (sz == 2'd0)      rq.wdata = (d & 32'hFF) * 32'h0101_0101;
      else if (sz == 2'd1) rq.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      else                 rq.wdata = d;
      if (stall >= TIMEOUT) begin
        rq.cycles = TIMEOUT;
        er.fault  = 1'b1;
        er.lat    = TIMEOUT + 2;
      end else begin
        rq.cycles = stall + 1;
        er.lat    = stall + rdelay + 4;
        er.fault  = err;
        if (!isWrite && !err) begin
          if (sz == 2'd0) begin
            ext = (rdata >> (8 * off)) & 32'hFF;
            if (!uns && ext[7]) ext = ext | 32'hFFFF_FF00;
          end else if (sz == 2'd1) begin
            ext = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && ext[15]) ext = ext | 32'hFFFF_0000;
          end else begin
            ext = rdata;
          end
          er.data = ext;
        end
      end
      expReqQ.push_back(rq);
    end
    er.issue = cyc + 1;
    expRespQ.push_back(er);
    curStall     = stall;
    curRespDelay = rdelay;
    curRdata     = rdata;
    curErr       = err;
    exValid = 1'b1;
    ldFlag  = ld;
    stFlag  = st;
    exAddr  = a;
    exData  = d;
    exSize  = sz;
    unsFlag = uns;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (LS_MON_ls_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("pulseSeen", 32'(seen), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exValid = 1'($urandom_range(0, 1));
      ldFlag  = exValid ? 1'b0 : 1'($urandom_range(0, 1));
      stFlag  = exValid ? 1'b0 : 1'($urandom_range(0, 1));
      exAddr  = $urandom;
      exData  = $urandom;
      exSize  = 2'($urandom_range(0, 3));
      unsFlag = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int          sel;
    logic        ld, st, uns, err;
    logic [1:0]  sz;
    logic [31:0] a;
    int          stall, rdelay;
    bit          reachedResp;

    rst = 1'b1;
    exValid = 1'b0; ldFlag = 1'b0; stFlag = 1'b0; unsFlag = 1'b0;
    exAddr = 32'd0; exData = 32'd0; exSize = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetPulse", 32'(LS_MON_ls_valid), 32'd0);
    checkOutput("resetReqValid", 32'(dmem_req_valid), 32'd0);
    checkOutput("resetRespReady", 32'(dmem_resp_ready), 32'd0);
    checkOutput("resetOutputs", {LS_WB_load_data | dmem_req_addr | dmem_req_wdata},
                32'd0);
    checkOutput("resetFlags", {27'd0, ls_misalign, ls_fault, dmem_req_we,
                dmem_req_wstrb[1:0] | dmem_req_wstrb[3:2]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkerOff = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(1, 0, 32'h0000_1003, 32'h0, 2'd0, 0, 0, 0, 32'h80FF_FF00, 0);
    applyStimulus(0, 1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_3001, 32'h0, 2'd2, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_4002, 32'h0, 2'd1, 1, 3, 0, 32'hBEEF_0000, 0);
    applyStimulus(1, 0, 32'h0000_5000, 32'h0, 2'd2, 0, TIMEOUT, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h0000_6000, 32'hCAFE_F00D, 2'd2, 0, 9, 0, 32'h0, 0);
    applyStimulus(1, 1, 32'h0000_7001, 32'h0, 2'd0, 0, 0, 2, 32'h1234_8000, 0);
    applyStimulus(1, 0, 32'h0000_8000, 32'h0, 2'd3, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0000_9004, 32'h0, 2'd2, 0, 1, 1, 32'h5555_AAAA, 1);
    applyStimulus(0, 1, 32'h0000_A001, 32'h0000_00A5, 2'd0, 0, 0, 0, 32'h0, 0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 2);
      ld  = (sel != 1);
      st  = (sel != 0);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      uns    = 1'($urandom_range(0, 1));
      stall  = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      rdelay = $urandom_range(0, 3);
      err    = ($urandom_range(0, 7) == 0);
      applyStimulus(ld, st, a, $urandom, sz, uns, stall, rdelay, $urandom, err);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end

    $display("[TB] reset during response wait");
    idleCycles(2);
    checkerOff = 1'b1;
    @(posedge clk);
    #1;
    curStall = 0;
    curRespDelay = 50;
    exValid = 1'b1; ldFlag = 1'b1; stFlag = 1'b0;
    exAddr = 32'h0000_B000; exSize = 2'd2; unsFlag = 1'b0;
    reachedResp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_resp_ready) begin
        reachedResp = 1'b1;
        break;
      end
    end
    checkOutput("reachedResp", 32'(reachedResp), 32'd1);
    exValid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midResetRespReady", 32'(dmem_resp_ready), 32'd0);
    checkOutput("midResetPulse", 32'(LS_MON_ls_valid | dmem_req_valid), 32'd0);
    checkOutput("midResetAddr", dmem_req_addr, 32'd0);
    checkOutput("midResetData", LS_WB_load_data | dmem_req_wdata, 32'd0);
    checkOutput("midResetFlags", {28'd0, dmem_req_wstrb} | 32'({ls_misalign, ls_fault,
                dmem_req_we}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkerOff = 1'b0;
    applyStimulus(1, 0, 32'h0000_C008, 32'h0, 2'd2, 0, 0, 0, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 1, 32'h0000_C00C, 32'h0BAD_F00D, 2'd2, 0, 1, 1, 32'h0, 0);

    idleCycles(4);
    checkOutput("respQueueDrained", 32'(expRespQ.size()), 32'd0);
    checkOutput("reqQueueDrained", 32'(expReqQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
